// File: rtl/cfg_reg_pkg.sv
// cfg_reg_pkg: shared FSM encoding and default sizing for the
// configuration-register write arbiter and its bank.
package cfg_reg_pkg;
   typedef enum logic [1:0] {IDLE, GRANT_WR, ACK} state_t;
   localparam int NREQ_DEF  = 4;
   localparam int NREG_DEF  = 8;
   localparam int WIDTH_DEF = 16;
endpackage

// File: rtl/cfg_reg_bank.sv
// cfg_reg_bank: NREG x WIDTH preset-on-reset register bank with
// per-register enables and a shared write data bus.
module cfg_reg_bank
   import cfg_reg_pkg::*;
#(
   parameter int NREG  = NREG_DEF,
   parameter int WIDTH = WIDTH_DEF
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [NREG-1:0]       en,
   input  logic [WIDTH-1:0]      d,
   output logic [NREG*WIDTH-1:0] reg_q
);
   genvar k, b;
   for (k = 0; k < NREG; k++) begin : g_reg
      for (b = 0; b < WIDTH; b++) begin : g_bit
         dff_set_en u_ff (
            .clk(clk),
            .set(rst),
            .en (en[k]),
            .d  (d[b]),
            .q  (reg_q[k*WIDTH+b])
         );
      end
   end
endmodule

// File: rtl/dff_set_en.sv
// dff_set_en: enable-gated flop with asynchronous preset to one.
module dff_set_en (
   input  logic clk,
   input  logic set,
   input  logic en,
   input  logic d,
   output logic q
);
   always_ff @(posedge clk or posedge set)
      if (set) q <= 1'b1;
      else if (en) q <= d;
endmodule

// File: rtl/cfg_reg_write_arbiter.sv
// cfg_reg_write_arbiter: round-robin arbiter that sequences one granted
// single-register write at a time into a preset-on-reset config bank.
module cfg_reg_write_arbiter
   import cfg_reg_pkg::*;
#(
   parameter int NREQ  = NREQ_DEF,
   parameter int NREG  = NREG_DEF,
   parameter int WIDTH = WIDTH_DEF,
   parameter int AW    = $clog2(NREG)
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [NREQ-1:0]       req_valid,
   input  logic [NREQ*AW-1:0]    req_addr,
   input  logic [NREQ*WIDTH-1:0] req_data,
   output logic [NREQ-1:0]       req_ack,
   output logic                  req_err,
   input  logic [AW-1:0]         rd_addr,
   output logic [WIDTH-1:0]      rd_data,
   output logic [NREG*WIDTH-1:0] reg_q,
   output logic                  busy
);
   localparam int IW = $clog2(NREQ);

   state_t           state_q, state_d;
   logic [IW-1:0]    rr_ptr_q, rr_ptr_d, gnt_idx_q, gnt_idx_d, pick;
   logic [AW-1:0]    gnt_addr_q, gnt_addr_d;
   logic [WIDTH-1:0] gnt_data_q, gnt_data_d;
   logic             err_q, err_d, in_range;
   logic [NREG-1:0]  en;

   // Scan downward so the nearest valid index at or after rr_ptr wins.
   always_comb begin
      pick = '0;
      for (int o = NREQ - 1; o >= 0; o--)
         if (req_valid[(int'(rr_ptr_q) + o) % NREQ]) pick = IW'((int'(rr_ptr_q) + o) % NREQ);
   end

   always_comb begin
      state_d    = state_q;
      rr_ptr_d   = rr_ptr_q;
      gnt_idx_d  = gnt_idx_q;
      gnt_addr_d = gnt_addr_q;
      gnt_data_d = gnt_data_q;
      err_d      = err_q;
      if (state_q == IDLE && |req_valid) begin
         state_d    = GRANT_WR;
         gnt_idx_d  = pick;
         gnt_addr_d = req_addr[int'(pick)*AW +: AW];
         gnt_data_d = req_data[int'(pick)*WIDTH +: WIDTH];
      end else if (state_q == GRANT_WR) begin
         state_d = ACK;
         err_d   = !in_range;
      end else if (state_q == ACK) begin
         state_d  = IDLE;
         rr_ptr_d = (gnt_idx_q == IW'(NREQ - 1)) ? '0 : gnt_idx_q + 1'b1;
      end
   end

   always_ff @(posedge clk or posedge rst)
      if (rst) begin
         state_q    <= IDLE;
         rr_ptr_q   <= '0;
         gnt_idx_q  <= '0;
         gnt_addr_q <= '0;
         gnt_data_q <= '0;
         err_q      <= 1'b0;
      end else begin
         state_q    <= state_d;
         rr_ptr_q   <= rr_ptr_d;
         gnt_idx_q  <= gnt_idx_d;
         gnt_addr_q <= gnt_addr_d;
         gnt_data_q <= gnt_data_d;
         err_q      <= err_d;
      end

   assign in_range = int'(gnt_addr_q) < NREG;
   assign en       = (state_q == GRANT_WR && in_range) ? ({{(NREG-1){1'b0}}, 1'b1} << gnt_addr_q) : '0;
   assign req_ack  = (state_q == ACK) ? ({{(NREQ-1){1'b0}}, 1'b1} << gnt_idx_q) : '0;
   assign req_err  = (state_q == ACK) && err_q;
   assign busy     = state_q != IDLE;
   assign rd_data  = (int'(rd_addr) < NREG) ? reg_q[int'(rd_addr)*WIDTH +: WIDTH] : '0;

   cfg_reg_bank #(.NREG(NREG), .WIDTH(WIDTH)) u_bank (
      .clk  (clk),
      .rst  (rst),
      .en   (en),
      .d    (gnt_data_q),
      .reg_q(reg_q)
   );
endmodule

// File: tb/tb_cfg_reg_write_arbiter.sv
// tb_cfg_reg_write_arbiter: scoreboard and vector-table bench for the
// round-robin config register write arbiter (NREG=8 and NREG=6 instances).
module tb_cfg_reg_write_arbiter;
   localparam int NREQ = 4, NREG = 8, WIDTH = 16, AW = 3, NREG6 = 6;

   logic                  clk = 1'b0, rst;
   logic [NREQ-1:0]       req_valid, req_ack;
   logic [NREQ*AW-1:0]    req_addr;
   logic [NREQ*WIDTH-1:0] req_data;
   logic                  req_err, busy;
   logic [AW-1:0]         rd_addr;
   logic [WIDTH-1:0]      rd_data;
   logic [NREG*WIDTH-1:0] reg_q;

   logic [NREQ-1:0]        v6, ack6;
   logic [NREQ*AW-1:0]     a6;
   logic [NREQ*WIDTH-1:0]  d6;
   logic                   err6, busy6;
   logic [AW-1:0]          rd6;
   logic [WIDTH-1:0]       rdd6;
   logic [NREG6*WIDTH-1:0] rq6;

   cfg_reg_write_arbiter #(.NREQ(NREQ), .NREG(NREG), .WIDTH(WIDTH)) dut (
      .clk(clk), .rst(rst), .req_valid(req_valid), .req_addr(req_addr), .req_data(req_data),
      .req_ack(req_ack), .req_err(req_err), .rd_addr(rd_addr), .rd_data(rd_data),
      .reg_q(reg_q), .busy(busy)
   );

   cfg_reg_write_arbiter #(.NREQ(NREQ), .NREG(NREG6), .WIDTH(WIDTH)) dut6 (
      .clk(clk), .rst(rst), .req_valid(v6), .req_addr(a6), .req_data(d6),
      .req_ack(ack6), .req_err(err6), .rd_addr(rd6), .rd_data(rdd6),
      .reg_q(rq6), .busy(busy6)
   );

   always #5 clk = ~clk;

   typedef struct {int idx; logic err; logic [AW-1:0] addr; logic [WIDTH-1:0] data;} exp_t;
   typedef struct {int idx; logic [AW-1:0] addr; logic [WIDTH-1:0] data;} vec_t;

   exp_t             sb[$];
   vec_t             vecs[6];
   logic [WIDTH-1:0] model[NREG];
   int               checks = 0, errors = 0;

   task automatic check(string name, logic [127:0] act, logic [127:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h", name, act, exp);
      end
   endtask

   function automatic logic [NREG*WIDTH-1:0] flat();
      logic [NREG*WIDTH-1:0] f;
      for (int k = 0; k < NREG; k++) f[k*WIDTH +: WIDTH] = model[k];
      return f;
   endfunction

   task automatic reset_model();
      for (int k = 0; k < NREG; k++) model[k] = '1;
      sb.delete();
   endtask

   // Scoreboard: every ack pops the oldest expected completion.
   always @(negedge clk)
      if (req_ack != 0) begin
         if (sb.size() == 0) check("unexpected_ack", 128'(req_ack), 128'(0));
         else begin
            exp_t e;
            e = sb.pop_front();
            check("ack_onehot", 128'(req_ack), 128'(1) << e.idx);
            check("ack_err", 128'(req_err), 128'(e.err));
            if (!e.err) model[e.addr] = e.data;
            check("bank_contents", 128'(reg_q), 128'(flat()));
         end
      end

   task automatic write_one(int idx, logic [AW-1:0] addr, logic [WIDTH-1:0] data);
      bit got = 0;
      req_valid[idx] = 1'b1;
      req_addr[idx*AW +: AW] = addr;
      req_data[idx*WIDTH +: WIDTH] = data;
      sb.push_back('{idx, 1'b0, addr, data});
      for (int t = 0; t < 12 && !got; t++) begin
         @(negedge clk);
         if (req_ack[idx]) got = 1;
      end
      req_valid[idx] = 1'b0;
      if (!got) check("ack_timeout", 128'(0), 128'(1));
   endtask

   task automatic write6(int idx, logic [AW-1:0] addr, logic [WIDTH-1:0] data, logic exp_err);
      bit got = 0;
      v6[idx] = 1'b1;
      a6[idx*AW +: AW] = addr;
      d6[idx*WIDTH +: WIDTH] = data;
      for (int t = 0; t < 12 && !got; t++) begin
         @(negedge clk);
         if (ack6 != 0) got = 1;
      end
      v6[idx] = 1'b0;
      check("ack6_onehot", 128'(ack6), got ? 128'(1) << idx : 128'(1) << 127);
      check("ack6_err", 128'(err6), 128'(exp_err));
   endtask

   initial begin
      int n, last;
      logic [WIDTH-1:0] old;
      vecs[0] = '{1, 3'd0, 16'hA5A5};
      vecs[1] = '{3, 3'd7, 16'h0001};
      vecs[2] = '{2, 3'd5, 16'h0000};
      vecs[3] = '{0, 3'd2, 16'hBEEF};
      vecs[4] = '{1, 3'd6, 16'h7E57};
      vecs[5] = '{3, 3'd1, 16'h8001};
      rst = 1'b1; req_valid = '0; req_addr = '0; req_data = '0; rd_addr = '0;
      v6 = '0; a6 = '0; d6 = '0; rd6 = '0;
      reset_model();
      repeat (3) @(negedge clk);
      check("rst_reg_q", 128'(reg_q), 128'({NREG*WIDTH{1'b1}}));
      check("rst_ack", 128'(req_ack), 128'(0));
      check("rst_busy", 128'(busy), 128'(0));
      rst = 1'b0;
      rd_addr = 3'd3;
      #1 check("rst_read3", 128'(rd_data), 128'(16'hFFFF));

      // single write by req0: cycle 0 here
      req_valid = 4'b0001; req_addr[0 +: AW] = 3'd2; req_data[0 +: WIDTH] = 16'h1234;
      sb.push_back('{0, 1'b0, 3'd2, 16'h1234});
      check("sw_busy_c0", 128'(busy), 128'(0));
      @(negedge clk);
      check("sw_busy_c1", 128'(busy), 128'(1));
      check("sw_ack_c1", 128'(req_ack), 128'(0));
      check("sw_reg2_c1", 128'(reg_q[2*WIDTH +: WIDTH]), 128'(16'hFFFF));
      @(negedge clk);
      check("sw_busy_c2", 128'(busy), 128'(1));
      check("sw_ack_c2", 128'(req_ack), 128'(4'b0001));
      check("sw_reg2_c2", 128'(reg_q[2*WIDTH +: WIDTH]), 128'(16'h1234));
      req_valid = '0;
      @(negedge clk);
      check("sw_ack_c3", 128'(req_ack), 128'(0));
      check("sw_busy_c3", 128'(busy), 128'(0));

      foreach (vecs[i]) begin
         write_one(vecs[i].idx, vecs[i].addr, vecs[i].data);
         rd_addr = vecs[i].addr;
         #1 check("vec_read", 128'(rd_data), 128'(vecs[i].data));
      end

      // asynchronous reset in the middle of a cycle
      @(posedge clk);
      #3 rst = 1'b1;
      #1;
      check("arst_reg_q", 128'(reg_q), 128'({NREG*WIDTH{1'b1}}));
      check("arst_ack", 128'(req_ack), 128'(0));
      check("arst_busy", 128'(busy), 128'(0));
      reset_model();
      @(negedge clk);
      rst = 1'b0;

      // reset during GRANT_WR loses the write and its ack
      req_valid = 4'b0001; req_addr[0 +: AW] = 3'd4; req_data[0 +: WIDTH] = 16'h00AA;
      @(negedge clk);
      check("rg_busy", 128'(busy), 128'(1));
      #1 rst = 1'b1;
      #1 req_valid = '0;
      #1 rst = 1'b0;
      reset_model();
      repeat (4) @(negedge clk);
      check("rg_reg4", 128'(reg_q[4*WIDTH +: WIDTH]), 128'(16'hFFFF));
      write_one(3, 3'd4, 16'h5555);
      check("rg_reg4_after", 128'(reg_q[4*WIDTH +: WIDTH]), 128'(16'h5555));

      // round robin with all requesters held valid
      for (int i = 0; i < NREQ; i++) begin
         req_addr[i*AW +: AW] = AW'(i);
         req_data[i*WIDTH +: WIDTH] = WIDTH'(i + 1);
      end
      for (int k = 0; k < 5; k++) sb.push_back('{k % NREQ, 1'b0, AW'(k % NREQ), WIDTH'(k % NREQ + 1)});
      req_valid = '1;
      n = 0; last = 0;
      for (int t = 1; t <= 40 && n < 5; t++) begin
         @(negedge clk);
         if (req_ack != 0) begin
            if (n > 0) check("rr_gap", 128'(t - last), 128'(3));
            last = t;
            n++;
            if (n == 5) req_valid = '0;
         end
      end
      check("rr_count", 128'(n), 128'(5));

      // withdraw after grant plus read-during-write
      @(negedge clk);
      old = model[6];
      req_valid = 4'b0100; req_addr[2*AW +: AW] = 3'd6; req_data[2*WIDTH +: WIDTH] = 16'hC3C3;
      rd_addr = 3'd6;
      sb.push_back('{2, 1'b0, 3'd6, 16'hC3C3});
      @(negedge clk);
      req_valid = '0;
      #1 check("wd_read_old", 128'(rd_data), 128'(old));
      @(negedge clk);
      check("wd_ack", 128'(req_ack), 128'(4'b0100));
      #1 check("wd_read_new", 128'(rd_data), 128'(16'hC3C3));
      @(negedge clk);
      check("wd_ack_gone", 128'(req_ack), 128'(0));
      check("sb_drained", 128'(sb.size()), 128'(0));

      // out-of-range on the six-register instance
      write6(0, 3'd5, 16'h5A5A, 1'b0);
      check("oor_in_range", 128'(rq6[5*WIDTH +: WIDTH]), 128'(16'h5A5A));
      @(negedge clk);
      write6(1, 3'd7, 16'h1111, 1'b1);
      check("oor_no_change", 128'(rq6), 128'({16'h5A5A, {5*WIDTH{1'b1}}}));
      rd6 = 3'd7;
      #1 check("oor_read", 128'(rdd6), 128'(0));

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule

// File: doc/cfg_reg_write_arbiter.md
# cfg_reg_write_arbiter

Round-robin write arbiter and sequencer for a bank of enable-gated, preset-on-reset configuration registers. Up to `NREQ` requesters post single-register writes with a valid/ack handshake. The block grants one requester at a time and drives exactly one register's enable for one cycle per granted write. It also exposes the whole bank to the datapath and gives a combinational read port. It sits between the host/config masters and the GPU pipeline configuration state.

## Interface
Parameters:
- `NREQ`, 4: number of requesters (2..8).
- `NREG`, 8: number of registers in the bank (2..32).
- `WIDTH`, 16: register width in bits.
- `AW`, `$clog2(NREG)`: address width (derived; do not override).

Ports:
- `clk`  in  1  sole clock, rising edge.
- `rst`  in  1  asynchronous, active-high reset. Drives the bank's preset input.
- `req_valid`  in  NREQ  per-requester write request.
- `req_addr`  in  NREQ*AW  flattened addresses; requester i occupies `[i*AW +: AW]`.
- `req_data`  in  NREQ*WIDTH  flattened write data; requester i occupies `[i*WIDTH +: WIDTH]`.
- `req_ack`  out  NREQ  one-cycle completion pulse, one-hot or zero.
- `req_err`  out  1  high with `req_ack` when the completed request addressed a register `>= NREG`.
- `rd_addr`  in  AW  read address.
- `rd_data`  out  WIDTH  combinational read of `reg[rd_addr]`. Reads 0 when `rd_addr >= NREG`.
- `reg_q`  out  NREG*WIDTH  all register contents, flattened; register k occupies `[k*WIDTH +: WIDTH]`.
- `busy`  out  1  high in GRANT_WR and ACK states.

## Operation
- The FSM has three states:
  - **IDLE**: if any `req_valid` is high, select the first asserted index searching upward from `rr_ptr` and wrapping modulo NREQ. Latch `gnt_idx`, `gnt_addr` and `gnt_data`, then go to GRANT_WR. Otherwise stay in IDLE.
  - **GRANT_WR**: if `gnt_addr < NREG`, assert `en[gnt_addr]` with `d = gnt_data` for this cycle only, so the register updates at the closing edge. If `gnt_addr >= NREG`, perform no write and set the error flag. Go to ACK.
  - **ACK**: `req_ack[gnt_idx] = 1`, and `req_err` is high if the error flag is set. Set `rr_ptr <= (gnt_idx + 1) mod NREQ`, then go to IDLE.
- Only one write is outstanding. Other requesters wait with `req_valid` held.
- Requester rules:
  - Hold `req_valid`, addr and data stable until `req_ack`.
  - The request is sampled only in IDLE. Changes after the grant are ignored, and the latched write completes.
  - Dropping `req_valid` after the grant does not cancel the write; the ack still pulses.
  - Keeping `req_valid` high through the ack cycle is a new request. It competes in the next IDLE cycle at the lowest priority.
- Reset values:
  - Every register bit is 1, because bank flops preset on `rst`.
  - `reg_q` is all ones.
  - `req_ack = 0`, `req_err = 0`, `busy = 0`.
  - State is IDLE, `rr_ptr = 0`, and all latched fields are 0.
- Reset mid-operation: a write in GRANT_WR that has not reached its closing edge is lost. Its register reads all ones and no ack is issued.
- No register enable is ever asserted outside GRANT_WR. At most one enable is high at a time.

## Timing
- Request seen in IDLE at cycle 0: GRANT_WR in cycle 1, register updated at the end of cycle 1, `reg_q` and `rd_data` show the new value in cycle 2, and the ack pulses in cycle 2.
- Peak throughput is one write per 3 cycles. IDLE is always visited between grants, so the cycle after an ack is never a write cycle.
- `rd_addr` equal to the register being written in cycle 1 returns the old value in cycle 1 and the new value from cycle 2.
- Under continuous requests from all NREQ requesters, each is granted once per 3*NREQ cycles.

## Structure
- Shared package `cfg_reg_pkg`:
  - FSM state enum {IDLE, GRANT_WR, ACK}.
  - Default values for NREQ, NREG and WIDTH.
- Sub-module `cfg_reg_bank`: NREG by WIDTH instances of the existing `dff_set_en` cell. It has a per-register enable, shared `d`, `set` tied to `rst`, and outputs `reg_q`.
- The arbiter logic is the round-robin pick plus the FSM. Together they are expected to be 120-250 lines.

## Test plan
- **Reset**: assert `rst` asynchronously mid-cycle.
  - `reg_q` goes all ones immediately; `req_ack = 0`, `busy = 0`.
  - After release, a read of `rd_addr = 3` returns `16'hFFFF`.
- **Single write**: req0 writes `addr = 2`, `data = 16'h1234` at cycle 0.
  - `busy` is high in cycles 1-2.
  - `reg[2] = 16'h1234` from cycle 2.
  - `req_ack = 4'b0001` in cycle 2 only.
- **Round robin**: all four requesters held valid, writing `addr = i` with `data = i + 1`.
  - Acks arrive in order 0, 1, 2, 3, 0, spaced 3 cycles apart.
  - No requester is granted twice before the others are granted.
- **Out of range**: with NREG = 6, req1 writes `addr = 7`.
  - `req_ack[1]` and `req_err` pulse together.
  - No register changes.
- **Reset during GRANT_WR**: pulse `rst` during cycle 1 of a write of `16'h00AA` to `reg[4]`.
  - `reg[4]` stays `16'hFFFF` and no ack appears.
  - Then req3 writes `16'h5555` to `reg[4]`, which succeeds.
- **Withdraw and read-during-write**:
  - req2 drops `req_valid` in cycle 1: its write still lands and the ack still pulses.
  - Same write, `rd_addr = gnt_addr`: `rd_data` returns the old value in cycle 1 and the new value in cycle 2.
